// File: rtl/register_alias_table_pkg.sv
// Shared definitions for the register alias table and the physical
// register allocator: default width parameters, the map-array typedef and
// the selector for where the speculative map is reloaded from.
package register_alias_table_pkg;

   localparam int unsigned DefArchRegIDWidth = 5;
   localparam int unsigned DefPhyRegIDWidth  = 6;
   localparam int unsigned DefBridWidth      = 2;
   localparam int unsigned DefCommitWidth    = 2;

   localparam int unsigned DefNumArchRegs    = 2 ** DefArchRegIDWidth;
   localparam int unsigned DefNumCheckpoints = 2 ** DefBridWidth;

   typedef logic [DefPhyRegIDWidth-1:0]    rat_tag_t;
   typedef rat_tag_t [DefNumArchRegs-1:0]  rat_map_t;

   // Source of a whole-map reload of the speculative map.
   typedef enum logic [1:0] {
      MapLoadNone,
      MapLoadRetire,
      MapLoadCheckpoint
   } rat_load_e;

endpackage

// File: rtl/register_alias_table_map_ram.sv
// rat_map_ram: speculative architectural->physical map storage.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset (identity map)
//   raddr_{a,b,c}_i        three combinational read ports; entry 0 reads as 0
//   rdata_{a,b,c}_o        read data
//   we_i, waddr_i, wdata_i single-entry write port
//   load_i, load_map_i     whole-map copy-load, takes priority over the write
//   map_o                  full current map contents
module rat_map_ram
   import register_alias_table_pkg::*;
#(
   parameter int unsigned ArchRegIDWidth = DefArchRegIDWidth,
   parameter int unsigned PhyRegIDWidth  = DefPhyRegIDWidth,
   localparam int unsigned NumArchRegs   = 2 ** ArchRegIDWidth
) (
   input  logic                                       clk_i,
   input  logic                                       rst_i,
   input  logic [ArchRegIDWidth-1:0]                  raddr_a_i,
   input  logic [ArchRegIDWidth-1:0]                  raddr_b_i,
   input  logic [ArchRegIDWidth-1:0]                  raddr_c_i,
   output logic [PhyRegIDWidth-1:0]                   rdata_a_o,
   output logic [PhyRegIDWidth-1:0]                   rdata_b_o,
   output logic [PhyRegIDWidth-1:0]                   rdata_c_o,
   input  logic                                       we_i,
   input  logic [ArchRegIDWidth-1:0]                  waddr_i,
   input  logic [PhyRegIDWidth-1:0]                   wdata_i,
   input  logic                                       load_i,
   input  logic [NumArchRegs-1:0][PhyRegIDWidth-1:0]  load_map_i,
   output logic [NumArchRegs-1:0][PhyRegIDWidth-1:0]  map_o
);

   logic [NumArchRegs-1:0][PhyRegIDWidth-1:0] map_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NumArchRegs; i++) begin
            map_q[i] <= PhyRegIDWidth'(i);
         end
      end else if (load_i) begin
         map_q <= load_map_i;
      end else if (we_i && waddr_i != '0) begin
         map_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = (raddr_a_i == '0) ? '0 : map_q[raddr_a_i];
   assign rdata_b_o = (raddr_b_i == '0) ? '0 : map_q[raddr_b_i];
   assign rdata_c_o = (raddr_c_i == '0) ? '0 : map_q[raddr_c_i];
   assign map_o     = map_q;

endmodule

// File: rtl/register_alias_table.sv
// register_alias_table: renames one instruction per cycle through a
// speculative map, keeps a retirement map updated by commits and one
// checkpoint map per branch ID for misprediction recovery.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   flush_i                            reload speculative map from retirement map
//   missprediction_i/_brid_i           reload speculative map from a checkpoint
//   rename_*                           upstream valid/ready, rs1/rs2/rd, branch info
//   alloc_tag_i, alloc_full_i          free tag and full flag from the allocator
//   allocate_o, allocate_new_checkpoint_o, allocate_brid_o  allocator controls
//   out_valid_o, out_ready_i           downstream handshake
//   out_*_tag_o                        renamed tags (registered, latency 1)
//   commit_i, commit_rd_i, commit_tag_i  retiring mappings, higher slot wins
module register_alias_table
   import register_alias_table_pkg::*;
#(
   parameter int unsigned ArchRegIDWidth = DefArchRegIDWidth,
   parameter int unsigned PhyRegIDWidth  = DefPhyRegIDWidth,
   parameter int unsigned BridWidth      = DefBridWidth,
   parameter int unsigned CommitWidth    = DefCommitWidth
) (
   input  logic                                       clk_i,
   input  logic                                       rst_i,
   input  logic                                       flush_i,
   input  logic                                       missprediction_i,
   input  logic [BridWidth-1:0]                       missprediction_brid_i,
   input  logic                                       rename_valid_i,
   output logic                                       rename_ready_o,
   input  logic [ArchRegIDWidth-1:0]                  rename_rs1_i,
   input  logic [ArchRegIDWidth-1:0]                  rename_rs2_i,
   input  logic [ArchRegIDWidth-1:0]                  rename_rd_i,
   input  logic                                       rename_new_checkpoint_i,
   input  logic [BridWidth-1:0]                       rename_brid_i,
   input  logic [PhyRegIDWidth-1:0]                   alloc_tag_i,
   input  logic                                       alloc_full_i,
   output logic                                       allocate_o,
   output logic                                       allocate_new_checkpoint_o,
   output logic [BridWidth-1:0]                       allocate_brid_o,
   output logic                                       out_valid_o,
   input  logic                                       out_ready_i,
   output logic [PhyRegIDWidth-1:0]                   out_rs1_tag_o,
   output logic [PhyRegIDWidth-1:0]                   out_rs2_tag_o,
   output logic [PhyRegIDWidth-1:0]                   out_rd_tag_o,
   output logic [PhyRegIDWidth-1:0]                   out_old_rd_tag_o,
   input  logic [CommitWidth-1:0]                     commit_i,
   input  logic [CommitWidth-1:0][ArchRegIDWidth-1:0] commit_rd_i,
   input  logic [CommitWidth-1:0][PhyRegIDWidth-1:0]  commit_tag_i
);

   localparam int unsigned NumArchRegs    = 2 ** ArchRegIDWidth;
   localparam int unsigned NumCheckpoints = 2 ** BridWidth;

   typedef logic [NumArchRegs-1:0][PhyRegIDWidth-1:0] map_t;

   map_t                                retire_q, retire_next;
   map_t                                spec_map, post_map, load_map;
   logic [NumCheckpoints-1:0][NumArchRegs-1:0][PhyRegIDWidth-1:0] ckpt_q;
   rat_load_e                           load_sel;
   logic [PhyRegIDWidth-1:0]            rs1_tag, rs2_tag, old_rd_tag;
   logic                                rd_nz, stage_free, accept;

   assign rd_nz          = rename_rd_i != '0;
   assign stage_free     = !out_valid_o || out_ready_i;
   assign rename_ready_o = stage_free && !flush_i && !missprediction_i
                           && !(rd_nz && alloc_full_i);
   assign accept         = rename_valid_i && rename_ready_o && !rst_i;

   assign allocate_o                = accept && rd_nz;
   assign allocate_new_checkpoint_o = accept && rename_new_checkpoint_i;
   assign allocate_brid_o           = rename_brid_i;

   // Retirement map with this cycle's commits applied; ascending slot order
   // makes the higher slot win on a same-rd collision.
   always_comb begin
      retire_next = retire_q;
      for (int unsigned s = 0; s < CommitWidth; s++) begin
         if (commit_i[s] && commit_rd_i[s] != '0) begin
            retire_next[commit_rd_i[s]] = commit_tag_i[s];
         end
      end
   end

   always_comb begin
      load_sel = MapLoadNone;
      if (flush_i) begin
         load_sel = MapLoadRetire;
      end else if (missprediction_i) begin
         load_sel = MapLoadCheckpoint;
      end
   end

   assign load_map = (load_sel == MapLoadRetire) ? retire_next
                                                 : map_t'(ckpt_q[missprediction_brid_i]);

   // Map as it will look after this instruction's rd update.
   always_comb begin
      post_map = spec_map;
      if (rd_nz) begin
         post_map[rename_rd_i] = alloc_tag_i;
      end
   end

   rat_map_ram #(
      .ArchRegIDWidth (ArchRegIDWidth),
      .PhyRegIDWidth  (PhyRegIDWidth)
   ) u_spec_map (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .raddr_a_i  (rename_rs1_i),
      .raddr_b_i  (rename_rs2_i),
      .raddr_c_i  (rename_rd_i),
      .rdata_a_o  (rs1_tag),
      .rdata_b_o  (rs2_tag),
      .rdata_c_o  (old_rd_tag),
      .we_i       (accept),
      .waddr_i    (rename_rd_i),
      .wdata_i    (alloc_tag_i),
      .load_i     (load_sel != MapLoadNone),
      .load_map_i (load_map),
      .map_o      (spec_map)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NumArchRegs; i++) begin
            retire_q[i] <= PhyRegIDWidth'(i);
         end
      end else begin
         retire_q <= retire_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned c = 0; c < NumCheckpoints; c++) begin
            for (int unsigned i = 0; i < NumArchRegs; i++) begin
               ckpt_q[c][i] <= PhyRegIDWidth'(i);
            end
         end
      end else if (accept && rename_new_checkpoint_i) begin
         ckpt_q[rename_brid_i] <= post_map;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_o      <= 1'b0;
         out_rs1_tag_o    <= '0;
         out_rs2_tag_o    <= '0;
         out_rd_tag_o     <= '0;
         out_old_rd_tag_o <= '0;
      end else if (flush_i || missprediction_i) begin
         out_valid_o <= 1'b0;
      end else if (stage_free) begin
         out_valid_o <= accept;
         if (accept) begin
            out_rs1_tag_o    <= rs1_tag;
            out_rs2_tag_o    <= rs2_tag;
            out_rd_tag_o     <= rd_nz ? alloc_tag_i : '0;
            out_old_rd_tag_o <= old_rd_tag;
         end
      end
   end

endmodule

// File: tb/tb_register_alias_table.sv
module tb_register_alias_table;

   logic clk = 1'b0;
   logic rst, flush, mis, valid, newck, full, oready;
   logic [1:0] mis_brid, brid;
   logic [4:0] rs1, rs2, rd;
   logic [5:0] atag;
   logic [1:0] commit;
   logic [1:0][4:0] commit_rd;
   logic [1:0][5:0] commit_tag;
   logic ready, alloc, alloc_ck, ovalid;
   logic [1:0] alloc_brid;
   logic [5:0] t_rs1, t_rs2, t_rd, t_old;

   int tests = 0;
   int fails = 0;

   // Behavioural model state
   int unsigned m_spec [32];
   int unsigned m_ret  [32];
   int unsigned m_ck   [4][32];
   bit          e_valid;
   int unsigned e_rs1, e_rs2, e_rd, e_old;

   always #5 clk = ~clk;

   register_alias_table #(
      .ArchRegIDWidth (5),
      .PhyRegIDWidth  (6),
      .BridWidth      (2),
      .CommitWidth    (2)
   ) dut (
      .clk_i                     (clk),
      .rst_i                     (rst),
      .flush_i                   (flush),
      .missprediction_i          (mis),
      .missprediction_brid_i     (mis_brid),
      .rename_valid_i            (valid),
      .rename_ready_o            (ready),
      .rename_rs1_i              (rs1),
      .rename_rs2_i              (rs2),
      .rename_rd_i               (rd),
      .rename_new_checkpoint_i   (newck),
      .rename_brid_i             (brid),
      .alloc_tag_i               (atag),
      .alloc_full_i              (full),
      .allocate_o                (alloc),
      .allocate_new_checkpoint_o (alloc_ck),
      .allocate_brid_o           (alloc_brid),
      .out_valid_o               (ovalid),
      .out_ready_i               (oready),
      .out_rs1_tag_o             (t_rs1),
      .out_rs2_tag_o             (t_rs2),
      .out_rd_tag_o              (t_rd),
      .out_old_rd_tag_o          (t_old),
      .commit_i                  (commit),
      .commit_rd_i               (commit_rd),
      .commit_tag_i              (commit_tag)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_ready();
      return (!e_valid || oready) && !flush && !mis && !(rd != 0 && full);
   endfunction

   task automatic model_step();
      int unsigned nret [32];
      bit acc;
      acc = valid && exp_ready() && !rst;
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_spec[i] = i; m_ret[i] = i;
            for (int c = 0; c < 4; c++) m_ck[c][i] = i;
         end
         e_valid = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_old = 0;
         return;
      end
      nret = m_ret;
      for (int s = 0; s < 2; s++)
         if (commit[s] && commit_rd[s] != 0) nret[commit_rd[s]] = commit_tag[s];
      if (flush) begin
         m_spec = nret;
         e_valid = 0;
      end else if (mis) begin
         m_spec = m_ck[mis_brid];
         e_valid = 0;
      end else begin
         if (!e_valid || oready) begin
            e_valid = acc;
            if (acc) begin
               e_rs1 = m_spec[rs1];
               e_rs2 = m_spec[rs2];
               e_rd  = (rd == 0) ? 0 : atag;
               e_old = m_spec[rd];
            end
         end
         if (acc) begin
            if (rd != 0) m_spec[rd] = atag;
            if (newck) m_ck[brid] = m_spec;
         end
      end
      m_ret = nret;
   endtask

   // Inputs are driven just after a falling edge; returns at the next falling edge.
   task automatic cycle();
      #1;
      chk("rename_ready", ready, exp_ready());
      chk("allocate", alloc, valid && exp_ready() && !rst && rd != 0);
      chk("alloc_new_ckpt", alloc_ck, valid && exp_ready() && !rst && newck);
      chk("alloc_brid", alloc_brid, brid);
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("out_valid", ovalid, e_valid);
      chk("out_rs1_tag", t_rs1, e_rs1);
      chk("out_rs2_tag", t_rs2, e_rs2);
      chk("out_rd_tag", t_rd, e_rd);
      chk("out_old_rd_tag", t_old, e_old);
   endtask

   task automatic idle();
      rst = 0; flush = 0; mis = 0; mis_brid = 0; valid = 0; newck = 0; brid = 0;
      full = 0; oready = 1; rs1 = 0; rs2 = 0; rd = 0; atag = 0;
      commit = 0; commit_rd = '0; commit_tag = '0;
   endtask

   task automatic rename(input int r1, input int r2, input int d, input int t);
      idle();
      valid = 1; rs1 = 5'(r1); rs2 = 5'(r2); rd = 5'(d); atag = 6'(t);
   endtask

   task automatic do_reset();
      idle(); rst = 1;
      cycle(); cycle();
      idle();
   endtask

   initial begin
      idle();
      @(negedge clk);
      do_reset();
      chk("rst_out_valid", ovalid, 0);
      chk("rst_rd_tag", t_rd, 0);
      chk("rst_rs1_tag", t_rs1, 0);

      // Basic rename and read-after-rename
      rename(3, 4, 5, 32); cycle();
      chk("lit_rs1", t_rs1, 3); chk("lit_rs2", t_rs2, 4);
      chk("lit_rd", t_rd, 32); chk("lit_old", t_old, 5);
      rename(5, 0, 0, 0); cycle();
      chk("lit_x5_renamed", t_rs1, 32); chk("lit_rd0_tag", t_rd, 0);

      // Downstream stall holds the stage
      for (int k = 0; k < 3; k++) begin
         rename(1, 2, 6, 40); oready = 0;
         #1;
         chk("lit_stall_ready", ready, 0);
         chk("lit_stall_alloc", alloc, 0);
         cycle();
         chk("lit_stall_hold", t_rs1, 32);
         chk("lit_stall_valid", ovalid, 1);
      end

      // Checkpoint and misprediction recovery
      do_reset();
      rename(0, 0, 5, 32); cycle();
      rename(0, 0, 0, 0); newck = 1; brid = 1; cycle();
      rename(0, 0, 5, 33); cycle();
      chk("lit_old_before_mis", t_old, 32);
      idle(); mis = 1; mis_brid = 1; cycle();
      chk("lit_mis_valid", ovalid, 0);
      rename(5, 0, 0, 0); cycle();
      chk("lit_mis_x5", t_rs1, 32);

      // Commit with same-cycle flush
      idle(); flush = 1; commit = 2'b01; commit_rd[0] = 5; commit_tag[0] = 33; cycle();
      chk("lit_flush_valid", ovalid, 0);
      rename(5, 0, 0, 0); cycle();
      chk("lit_flush_bypass_x5", t_rs1, 33);

      // Allocator full
      rename(0, 0, 7, 50); full = 1;
      #1;
      chk("lit_full_ready", ready, 0);
      chk("lit_full_alloc", alloc, 0);
      cycle();
      rename(5, 0, 0, 0); full = 1;
      #1;
      chk("lit_full_rd0_ready", ready, 1);
      chk("lit_full_rd0_alloc", alloc, 0);
      cycle();
      chk("lit_full_rd0_valid", ovalid, 1);
      chk("lit_full_rd0_tag", t_rd, 0);

      // Same-rd commit collision
      idle(); commit = 2'b11; commit_rd[0] = 9; commit_tag[0] = 40;
      commit_rd[1] = 9; commit_tag[1] = 41; cycle();
      idle(); flush = 1; cycle();
      rename(9, 0, 0, 0); cycle();
      chk("lit_commit_collision_x9", t_rs1, 41);

      // Reset during a held transaction
      rename(0, 0, 3, 50); oready = 0; cycle();
      chk("lit_held_valid", ovalid, 1);
      idle(); rst = 1; oready = 0; cycle();
      chk("lit_rst_drop_valid", ovalid, 0);
      idle(); cycle();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         idle();
         rst      = ($urandom_range(0, 299) == 0);
         flush    = ($urandom_range(0, 29) == 0);
         mis      = ($urandom_range(0, 19) == 0);
         mis_brid = 2'($urandom_range(0, 3));
         valid    = ($urandom_range(0, 3) != 0);
         newck    = ($urandom_range(0, 5) == 0);
         brid     = 2'($urandom_range(0, 3));
         full     = ($urandom_range(0, 7) == 0);
         oready   = ($urandom_range(0, 3) != 0);
         rs1      = 5'($urandom_range(0, 15));
         rs2      = 5'($urandom_range(0, 15));
         rd       = 5'($urandom_range(0, 15));
         atag     = 6'($urandom_range(0, 63));
         for (int s = 0; s < 2; s++) begin
            commit[s]     = ($urandom_range(0, 2) == 0);
            commit_rd[s]  = 5'($urandom_range(0, 15));
            commit_tag[s] = 6'($urandom_range(0, 63));
         end
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
